// File: rtl/uart_queue_core.sv
// rtl/uart_queue_core.sv - 8N1 UART core with rx synchroniser and first-word-fall-through tx/rx byte queues

// Circular first-word-fall-through byte queue; the head is always on data_o.
module uart_queue_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q;
   logic [DEPTH_LOG2-1:0] rd_ptr_q;
   logic [DEPTH_LOG2:0]   count_q;
   logic                  push_ok_d;
   logic                  pop_ok_d;

   // A push into a full queue is dropped even when a pop happens in the same cycle.
   assign push_ok_d = push_i && (count_q != FULL_COUNT);
   assign pop_ok_d  = pop_i && (count_q != '0);

   assign data_o  = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == FULL_COUNT);

   // Storage, pointers (wrap naturally at the power-of-two depth) and occupancy.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok_d) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop_ok_d) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok_d, pop_ok_d})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// Top: serial pins on one side, byte push/pop queue interface on the other.
module uart_queue_core #(
   parameter int CLK_HZ      = 12000000,
   parameter int BAUD        = 115200,
   parameter int QDEPTH_LOG2 = 3
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_i,
   output logic       tx_o,
   input  logic       txq_we_i,
   input  logic [7:0] tx_byte_i,
   output logic       txq_full_o,
   input  logic       rxq_re_i,
   output logic [7:0] rx_byte_o,
   output logic       rxq_ready_o,
   output logic       rxq_full_o,
   output logic       tx_busy_o
);

   localparam int DIV = CLK_HZ / BAUD;
   localparam int CW  = $clog2(DIV + 1);
   localparam logic [CW-1:0] BIT_RELOAD  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_RELOAD = CW'(DIV / 2 - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_e;

   // ---------------- transmit side ----------------
   logic       txq_empty;
   logic [7:0] txq_head;
   logic       tx_pop_d;

   state_e     tx_state_q;
   logic [CW-1:0] tx_cnt_q;
   logic [2:0] tx_bit_q;
   logic [7:0] tx_shift_q;
   logic       tx_q;
   logic       tx_busy_q;

   uart_queue_fifo #(.WIDTH(8), .DEPTH_LOG2(QDEPTH_LOG2)) u_txq (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (txq_we_i),
      .data_i  (tx_byte_i),
      .pop_i   (tx_pop_d),
      .data_o  (txq_head),
      .empty_o (txq_empty),
      .full_o  (txq_full_o)
   );

   // The transmitter only takes a new byte from IDLE, where tx_busy is already low.
   assign tx_pop_d = (tx_state_q == S_IDLE) && !txq_empty;

   // Transmit FSM: start bit, 8 data bits LSB first, stop bit, each DIV cycles.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tx_state_q <= S_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_q       <= 1'b1;
         tx_busy_q  <= 1'b0;
      end else begin
         case (tx_state_q)
            S_IDLE: begin
               if (!txq_empty) begin
                  tx_shift_q <= txq_head;
                  tx_q       <= 1'b0;
                  tx_busy_q  <= 1'b1;
                  tx_cnt_q   <= BIT_RELOAD;
                  tx_state_q <= S_START;
               end
            end
            S_START: begin
               if (tx_cnt_q == '0) begin
                  tx_q       <= tx_shift_q[0];
                  tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                  tx_bit_q   <= '0;
                  tx_cnt_q   <= BIT_RELOAD;
                  tx_state_q <= S_DATA;
               end else begin
                  tx_cnt_q <= tx_cnt_q - 1'b1;
               end
            end
            S_DATA: begin
               if (tx_cnt_q == '0) begin
                  tx_cnt_q <= BIT_RELOAD;
                  if (tx_bit_q == 3'd7) begin
                     tx_q       <= 1'b1;
                     tx_state_q <= S_STOP;
                  end else begin
                     tx_q       <= tx_shift_q[0];
                     tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                     tx_bit_q   <= tx_bit_q + 1'b1;
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q - 1'b1;
               end
            end
            S_STOP: begin
               if (tx_cnt_q == '0) begin
                  tx_busy_q  <= 1'b0;
                  tx_state_q <= S_IDLE;
               end else begin
                  tx_cnt_q <= tx_cnt_q - 1'b1;
               end
            end
            default: tx_state_q <= S_IDLE;
         endcase
      end
   end

   assign tx_o      = tx_q;
   assign tx_busy_o = tx_busy_q;

   // ---------------- receive side ----------------
   logic       rx_meta_q;
   logic       rx_sync_q;
   logic       rx_prev_q;
   logic       rx_fall_d;

   state_e     rx_state_q;
   logic [CW-1:0] rx_cnt_q;
   logic [2:0] rx_bit_q;
   logic [7:0] rx_shift_q;
   logic [7:0] rx_hold_q;
   logic       rx_valid_q;
   logic       rx_push_last_q;
   logic       rx_push_d;
   logic       rxq_empty;

   // Two-flop synchroniser plus a delayed copy for falling-edge detection; idle-high reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   assign rx_fall_d = rx_prev_q && !rx_sync_q;

   // Hand the holding register to the queue when there is room, never on consecutive cycles.
   assign rx_push_d = rx_valid_q && !rxq_full_o && !rx_push_last_q;

   uart_queue_fifo #(.WIDTH(8), .DEPTH_LOG2(QDEPTH_LOG2)) u_rxq (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (rx_push_d),
      .data_i  (rx_hold_q),
      .pop_i   (rxq_re_i),
      .data_o  (rx_byte_o),
      .empty_o (rxq_empty),
      .full_o  (rxq_full_o)
   );

   assign rxq_ready_o = !rxq_empty;

   // Receive FSM and holding register; a completing byte wins over a same-cycle clear.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rx_state_q     <= S_IDLE;
         rx_cnt_q       <= '0;
         rx_bit_q       <= '0;
         rx_shift_q     <= '0;
         rx_hold_q      <= '0;
         rx_valid_q     <= 1'b0;
         rx_push_last_q <= 1'b0;
      end else begin
         rx_push_last_q <= rx_push_d;
         if (rx_push_d) rx_valid_q <= 1'b0;
         case (rx_state_q)
            S_IDLE: begin
               if (rx_fall_d) begin
                  rx_cnt_q   <= HALF_RELOAD;
                  rx_state_q <= S_START;
               end
            end
            S_START: begin
               if (rx_cnt_q == '0) begin
                  if (rx_sync_q) begin
                     rx_state_q <= S_IDLE;
                  end else begin
                     rx_cnt_q   <= BIT_RELOAD;
                     rx_bit_q   <= '0;
                     rx_state_q <= S_DATA;
                  end
               end else begin
                  rx_cnt_q <= rx_cnt_q - 1'b1;
               end
            end
            S_DATA: begin
               if (rx_cnt_q == '0) begin
                  rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                  rx_cnt_q   <= BIT_RELOAD;
                  if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
                  else                  rx_bit_q   <= rx_bit_q + 1'b1;
               end else begin
                  rx_cnt_q <= rx_cnt_q - 1'b1;
               end
            end
            S_STOP: begin
               if (rx_cnt_q == '0) begin
                  if (rx_sync_q) begin
                     rx_hold_q  <= rx_shift_q;
                     rx_valid_q <= 1'b1;
                  end
                  rx_state_q <= S_IDLE;
               end else begin
                  rx_cnt_q <= rx_cnt_q - 1'b1;
               end
            end
            default: rx_state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_queue_core.sv
// tb/tb_uart_queue_core.sv - directed self-checking bench for uart_queue_core

module tb_uart_queue_core;

   localparam int DIV = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_drv = 1'b1;
   logic       loop_en = 1'b0;
   logic       txq_we = 1'b0;
   logic [7:0] tx_byte = 8'h00;
   logic       rxq_re = 1'b0;
   logic       rx_line;
   logic       tx;
   logic       txq_full;
   logic [7:0] rx_byte;
   logic       rxq_ready;
   logic       rxq_full;
   logic       tx_busy;

   int vectors = 0;
   int errors  = 0;

   assign rx_line = loop_en ? tx : rx_drv;

   always #5 clk = ~clk;

   uart_queue_core #(.CLK_HZ(1600000), .BAUD(100000), .QDEPTH_LOG2(3)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .rx_i        (rx_line),
      .tx_o        (tx),
      .txq_we_i    (txq_we),
      .tx_byte_i   (tx_byte),
      .txq_full_o  (txq_full),
      .rxq_re_i    (rxq_re),
      .rx_byte_o   (rx_byte),
      .rxq_ready_o (rxq_ready),
      .rxq_full_o  (rxq_full),
      .tx_busy_o   (tx_busy)
   );

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [7:0] b);
      tx_byte = b;
      txq_we  = 1'b1;
      @(negedge clk);
      txq_we  = 1'b0;
   endtask

   task automatic pop();
      rxq_re = 1'b1;
      @(negedge clk);
      rxq_re = 1'b0;
   endtask

   task automatic send_serial(input logic [7:0] b, input logic stop_bit);
      logic [9:0] frame;
      frame = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx_drv = frame[i];
         tick(DIV);
      end
      rx_drv = 1'b1;
   endtask

   task automatic wait_ready(input string tag);
      int w = 0;
      while (rxq_ready !== 1'b1 && w < 400) begin
         @(negedge clk);
         w++;
      end
      vectors++;
      if (rxq_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_wait rxq_ready=%b want 1 after %0d cycles", tag, rxq_ready, w);
      end
   endtask

   task automatic test_reset();
      int bad;
      tick(3);
      vectors++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx got %b want 1", tx); end
      vectors++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", tx_busy); end
      vectors++; if (rxq_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", rxq_ready); end
      vectors++; if (rxq_full !== 1'b0) begin errors++; $display("FAIL rst_rxq_full got %b want 0", rxq_full); end
      vectors++; if (txq_full !== 1'b0) begin errors++; $display("FAIL rst_txq_full got %b want 0", txq_full); end
      vectors++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL rst_rx_byte got %h want 00", rx_byte); end
      rst = 1'b0;
      tick(2);
      push(8'h55);
      push(8'h0F);
      tick(50);
      vectors++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL midframe_busy got %b want 1", tx_busy); end
      rst = 1'b1;
      #1;
      vectors++; if (tx !== 1'b1) begin errors++; $display("FAIL abort_tx got %b want 1", tx); end
      vectors++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", tx_busy); end
      vectors++; if (rxq_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got %b want 0", rxq_ready); end
      vectors++; if (txq_full !== 1'b0) begin errors++; $display("FAIL abort_txq_full got %b want 0", txq_full); end
      tick(2);
      rst = 1'b0;
      bad = 0;
      repeat (200) begin
         if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
         tick(1);
      end
      vectors++; if (bad != 0) begin errors++; $display("FAIL queue_flushed active_cycles=%0d want 0", bad); end
   endtask

   task automatic test_tx_frame();
      logic [9:0] frame;
      int w;
      int bad;
      frame = {1'b1, 8'hA3, 1'b0};
      push(8'hA3);
      w = 0;
      while (tx !== 1'b0 && w < 10) begin
         tick(1);
         w++;
      end
      vectors++; if (w < 1 || w > 2) begin errors++; $display("FAIL tx_start_latency got %0d want 1..2", w); end
      for (int b = 0; b < 10; b++) begin
         bad = 0;
         repeat (DIV) begin
            if (tx !== frame[b] || tx_busy !== 1'b1) bad++;
            tick(1);
         end
         vectors++;
         if (bad != 0) begin
            errors++;
            $display("FAIL tx_bit%0d bad_cycles=%0d want 0 (level %b)", b, bad, frame[b]);
         end
      end
      vectors++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL tx_busy_end got %b want 0", tx_busy); end
      vectors++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_idle_end got %b want 1", tx); end
   endtask

   task automatic test_loopback();
      logic [7:0] exp [3];
      exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h5A;
      loop_en = 1'b1;
      tick(2);
      for (int k = 0; k < 3; k++) push(exp[k]);
      for (int k = 0; k < 3; k++) begin
         wait_ready("loop");
         vectors++; if (rx_byte !== exp[k]) begin errors++; $display("FAIL loop_byte%0d got %h want %h", k, rx_byte, exp[k]); end
         pop();
         vectors++; if (rxq_ready !== 1'b0) begin errors++; $display("FAIL loop_ready_drop%0d got %b want 0", k, rxq_ready); end
      end
   endtask

   task automatic test_fifo_full();
      int w;
      push(8'h11);
      w = 0;
      while (tx_busy !== 1'b1 && w < 10) begin
         tick(1);
         w++;
      end
      vectors++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL full_pre_busy got %b want 1", tx_busy); end
      for (int i = 0; i < 8; i++) begin
         if (i == 7) begin
            vectors++; if (txq_full !== 1'b0) begin errors++; $display("FAIL full_at7 got %b want 0", txq_full); end
         end
         push(8'h80 + 8'(i));
      end
      vectors++; if (txq_full !== 1'b1) begin errors++; $display("FAIL full_at8 got %b want 1", txq_full); end
      push(8'h77);
      vectors++; if (txq_full !== 1'b1) begin errors++; $display("FAIL full_after_drop got %b want 1", txq_full); end
      for (int k = 0; k < 9; k++) begin
         logic [7:0] e;
         e = (k == 0) ? 8'h11 : 8'h80 + 8'(k - 1);
         wait_ready("drain");
         vectors++; if (rx_byte !== e) begin errors++; $display("FAIL drain_byte%0d got %h want %h", k, rx_byte, e); end
         pop();
      end
      tick(400);
      vectors++; if (rxq_ready !== 1'b0) begin errors++; $display("FAIL drain_extra_frame ready=%b want 0 (byte %h)", rxq_ready, rx_byte); end
      vectors++; if (tx_busy !== 1'b0 || txq_full !== 1'b0) begin errors++; $display("FAIL drain_idle busy=%b full=%b want 0 0", tx_busy, txq_full); end
      loop_en = 1'b0;
   endtask

   task automatic test_rx_overflow();
      rx_drv = 1'b1;
      tick(5);
      for (int k = 1; k <= 9; k++) begin
         send_serial(8'(k), 1'b1);
         tick(2);
         if (k == 7) begin
            vectors++; if (rxq_full !== 1'b0) begin errors++; $display("FAIL ovf_full_at7 got %b want 0", rxq_full); end
         end
         if (k >= 8) begin
            vectors++; if (rxq_full !== 1'b1) begin errors++; $display("FAIL ovf_full_at%0d got %b want 1", k, rxq_full); end
         end
      end
      vectors++; if (rx_byte !== 8'h01) begin errors++; $display("FAIL ovf_head got %h want 01", rx_byte); end
      for (int k = 1; k <= 9; k++) begin
         tick(1);
         wait_ready("ovf");
         vectors++; if (rx_byte !== 8'(k)) begin errors++; $display("FAIL ovf_pop%0d got %h want %h", k, rx_byte, 8'(k)); end
         pop();
      end
      tick(5);
      vectors++; if (rxq_ready !== 1'b0 || rxq_full !== 1'b0) begin errors++; $display("FAIL ovf_empty ready=%b full=%b want 0 0", rxq_ready, rxq_full); end
   endtask

   task automatic test_glitch_framing();
      rx_drv = 1'b0;
      tick(DIV / 4);
      rx_drv = 1'b1;
      tick(300);
      vectors++; if (rxq_ready !== 1'b0) begin errors++; $display("FAIL glitch_byte ready=%b want 0", rxq_ready); end
      send_serial(8'h3C, 1'b0);
      tick(200);
      vectors++; if (rxq_ready !== 1'b0) begin errors++; $display("FAIL framing_byte ready=%b want 0", rxq_ready); end
      send_serial(8'hC6, 1'b1);
      wait_ready("recover");
      vectors++; if (rx_byte !== 8'hC6) begin errors++; $display("FAIL recover_byte got %h want c6", rx_byte); end
      pop();
   endtask

   initial begin
      test_reset();
      test_tx_frame();
      test_loopback();
      test_fifo_full();
      test_rx_overflow();
      test_glitch_framing();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
